mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Sits directly downstream of the instruction and data caches. It merges their two single-beat memory ports (strobe/ready protocol) into one AXI4 master with single-beat bursts, towards the SoC interconnect. Uncached accesses pass through the caches unchanged and are handled here identically to line fills and writebacks. One transaction is in flight at a time.

## Interface
Parameters:
- A_WIDTH, 32, address width on both client ports and on AXI.
- AXI_ID, 4'h0, constant ARID/AWID driven on every transaction.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_a  in  A_WIDTH  I-side address.
- i_strobe  in  1  I-side request; read only.
- i_size  in  2  I-side size: 0 = byte, 1 = half, 2 = word.
- i_din  out  32  I-side read data.
- i_ready  out  1  I-side completion pulse.
- d_a  in  A_WIDTH  D-side address.
- d_dout  in  32  D-side write data, lane-aligned.
- d_din  out  32  D-side read data.
- d_strobe  in  1  D-side request.
- d_rw  in  1  D-side direction: 1 = write.
- d_wen  in  4  D-side byte enables.
- d_size  in  2  D-side size.
- d_ready  out  1  D-side completion pulse.
- araddr/arsize/arvalid out, arready in: AXI AR channel. ARLEN = 0; ARBURST = INCR.
- rdata/rresp/rvalid in, rready out: AXI R channel.
- awaddr/awsize/awvalid out, awready in: AXI AW channel. AWLEN = 0.
- wdata/wstrb/wvalid/wlast out, wready in: AXI W channel. WLAST = 1.
- bresp/bvalid in, bready out: AXI B channel.

## Operation
States:
- IDLE: arbitrate. Capture the winner's address, size, write data, wen and rw into registers. Go to RD_ADDR if the access is a read, otherwise WR_REQ.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata and go to RESP.
- WR_REQ: awvalid and wvalid are both raised on entry. Each is dropped independently after its own handshake, tracked with the aw_done and w_done flags. When both are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, go to RESP.
- RESP: for exactly one cycle, assert ready of the granted client and drive its din from the captured rdata. Then return to IDLE.

Signal mapping:
- arsize/awsize = {1'b0, size}.
- wstrb = captured wen.
- The I-side is never a write: I-side transactions always take the read path.
- rresp and bresp are ignored; the transaction completes normally regardless.
- Outside RESP, i_din and d_din hold their last captured value; i_ready and d_ready are 0.

Arbitration (fixed priority):
- D-side wins whenever d_strobe = 1.
- A losing request stays pending. The client must hold its request stable until its ready pulse.
- The client may present a new request in the cycle after its ready pulse.

## Timing
- Reset values: state IDLE; all valid/ready outputs 0; bready and rready 0; din registers 0; address and data outputs 0; rotating priority pointer set to the D-side.
- Reset mid-transaction: abandon the transaction immediately with no completion pulse. The slave is reset by the same rst.
- Read latency with zero-wait slave (arready = 1, rvalid the cycle after AR): strobe sampled at edge 0, arvalid cycle 1, rvalid cycle 2, ready cycle 3.
- Write latency with zero-wait slave: ready 3 cycles after the strobe is sampled.
- arvalid, awvalid and wvalid never drop before their handshake. Address and data remain stable while valid.
- awready and wready in the same cycle, or in either order: both orders are accepted; WR_RESP is entered only after the later handshake.
- bvalid is never early in a correct slave; bready is asserted only in WR_RESP.
- Back-to-back requests: IDLE is occupied for one cycle between transactions, so the minimum turnaround is one cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the client that was not granted last. A 1-bit last-grant pointer is updated at each IDLE grant.
- ARB_ROUND_ROBIN_EN undefined: fixed D-side priority. The pointer logic is not built.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP);
  - the client enum (CLI_I, CLI_D);
  - AXI constants BURST_INCR and LEN_SINGLE.
- Sub-module arb_pick: combinational grant from i_strobe, d_strobe and the last-grant pointer, with the round-robin logic under the macro.

## Test plan
- Single D read, zero-wait slave, d_a = 32'h1000_0040, slave returns 32'hDEAD_BEEF: araddr = 32'h1000_0040, arsize = 3'b010; d_ready for one cycle at cycle 3 with d_din = 32'hDEADBEEF; i_ready stays 0.
- D write d_wen = 4'b0011, d_dout = 32'h0000_1234; slave sends wready 2 cycles after awready, then bvalid after 3 more cycles: wstrb = 4'b0011, awvalid held until awready, d_ready exactly once, only after bvalid.
- I and D strobes rise in the same cycle, fixed priority: D transaction first, then I. With ARB_ROUND_ROBIN_EN and last grant = D: I first.
- Assert rst while in RD_DATA with rvalid pending: next cycle all valid/ready outputs are 0, state is IDLE, and no d_ready pulse occurs.
- Read with rresp = 2'b10 and rdata = 32'hFFFF_0000: completes normally, i_din = 32'hFFFF0000, i_ready pulses once.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg : shared types and AXI constants for the I/D cache bus arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } client_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick : combinational I/D grant; round-robin tie-break under
//            ARB_ROUND_ROBIN_EN, fixed D-side priority otherwise
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_pick
  import mem_bus_pkg::*;
(
  input  logic    i_strobe,
  input  logic    d_strobe,
  input  client_t last_grant,
  output logic    req,
  output client_t grant
);

  always_comb begin
    req = i_strobe | d_strobe;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the client that lost last time goes first.
    if (i_strobe && d_strobe) begin
      grant = (last_grant == CLI_D) ? CLI_I : CLI_D;
    end else begin
      grant = d_strobe ? CLI_D : CLI_I;
    end
`else
    grant = d_strobe ? CLI_D : CLI_I;
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : merges I- and D-cache strobe/ready ports into a single
//                   single-beat AXI4 master, one transaction in flight.
//                   ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int         A_WIDTH = 32,
  parameter logic [3:0] AXI_ID  = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  // I-side client
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  input  logic [1:0]         i_size,
  output logic [31:0]        i_din,
  output logic               i_ready,
  // D-side client
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_dout,
  output logic [31:0]        d_din,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  output logic               d_ready,
  // AXI AR
  output logic [3:0]         arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  // AXI R
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  // AXI AW
  output logic [3:0]         awid,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  // AXI W
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  // AXI B
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  state_t             state;
  state_t             state_nx;
  client_t            grant_q;
  client_t            pick_grant;
  client_t            last_grant;
  logic               pick_req;
  logic [A_WIDTH-1:0] addr_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wen_q;
  logic               aw_done;
  logic               w_done;
  logic [31:0]        i_din_q;
  logic [31:0]        d_din_q;

  arb_pick u_arb_pick (
    .i_strobe   (i_strobe),
    .d_strobe   (d_strobe),
    .last_grant (last_grant),
    .req        (pick_req),
    .grant      (pick_grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= CLI_D;
    end else if (state == IDLE && pick_req) begin
      last_grant <= pick_grant;
    end
  end
`else
  assign last_grant = CLI_D;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state)
      IDLE: begin
        // The I-side never writes, so only a D grant can take the write path.
        if (pick_req) begin
          state_nx = (pick_grant == CLI_D && d_rw) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nx = RESP;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nx = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = RESP;
      end
      RESP: begin
        i_ready  = (grant_q == CLI_I);
        d_ready  = (grant_q == CLI_D);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= CLI_D;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      wen_q   <= 4'h0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      i_din_q <= 32'h0;
      d_din_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_req) begin
            grant_q <= pick_grant;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (pick_grant == CLI_D) begin
              addr_q  <= d_a;
              size_q  <= d_size;
              wdata_q <= d_dout;
              wen_q   <= d_wen;
            end else begin
              addr_q  <= i_a;
              size_q  <= i_size;
              wdata_q <= 32'h0;
              wen_q   <= 4'h0;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        RD_DATA: begin
          if (rvalid) begin
            if (grant_q == CLI_D) d_din_q <= rdata;
            else                  i_din_q <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_din   = i_din_q;
  assign d_din   = d_din_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;

  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;

  // Error responses complete like OKAY; the caches have no error path.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_a;
  logic        i_strobe;
  logic [1:0]  i_size;
  logic [31:0] i_din;
  logic        i_ready;
  logic [31:0] d_a;
  logic [31:0] d_dout;
  logic [31:0] d_din;
  logic        d_strobe;
  logic        d_rw;
  logic [3:0]  d_wen;
  logic [1:0]  d_size;
  logic        d_ready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_chk;
  int n_fail;

  mem_bus_arbiter #(.A_WIDTH(32), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_strobe(i_strobe), .i_size(i_size), .i_din(i_din), .i_ready(i_ready),
    .d_a(d_a), .d_dout(d_dout), .d_din(d_din), .d_strobe(d_strobe), .d_rw(d_rw),
    .d_wen(d_wen), .d_size(d_size), .d_ready(d_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    i_a = '0; i_strobe = 0; i_size = 0;
    d_a = '0; d_dout = '0; d_strobe = 0; d_rw = 0; d_wen = 0; d_size = 0;
    arready = 0; rdata = '0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    tick; tick;

    // Reset state
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid",  wvalid,  0);
    check("rst_rready",  rready,  0);
    check("rst_bready",  bready,  0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_araddr",  araddr,  0);
    check("rst_i_din",   i_din,   0);
    check("rst_d_din",   d_din,   0);
    check("rst_wlast",   wlast,   1);
    check("rst_arlen",   arlen,   0);
    check("rst_arburst", arburst, 2'b01);
    rst = 1'b0;
    tick;

    // Single D read, zero-wait slave
    d_a = 32'h1000_0040; d_size = 2'd2; d_rw = 0; d_strobe = 1; arready = 1;
    tick;
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr",  araddr,  32'h1000_0040);
    check("t1_arsize",  arsize,  3'b010);
    check("t1_rready_c1", rready, 0);
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    tick;
    check("t1_rready_c2", rready, 1);
    check("t1_arvalid_c2", arvalid, 0);
    check("t1_d_ready_c2", d_ready, 0);
    tick;
    rvalid = 0;
    check("t1_d_ready_c3", d_ready, 1);
    check("t1_d_din",   d_din,   32'hDEAD_BEEF);
    check("t1_i_ready", i_ready, 0);
    d_strobe = 0;
    tick;
    check("t1_d_ready_c4", d_ready, 0);
    check("t1_d_din_hold", d_din, 32'hDEAD_BEEF);
    tick;

    // D write, wready 2 cycles after awready, bvalid 3 cycles after that
    d_a = 32'h2000_0010; d_size = 2'd1; d_rw = 1; d_wen = 4'b0011;
    d_dout = 32'h0000_1234; d_strobe = 1; awready = 1; wready = 0; arready = 0;
    tick;
    check("t2_awvalid_c1", awvalid, 1);
    check("t2_wvalid_c1",  wvalid,  1);
    check("t2_wstrb",  wstrb,  4'b0011);
    check("t2_wdata",  wdata,  32'h0000_1234);
    check("t2_awaddr", awaddr, 32'h2000_0010);
    check("t2_awsize", awsize, 3'b001);
    check("t2_arvalid", arvalid, 0);
    tick;
    awready = 0;
    check("t2_awvalid_c2", awvalid, 0);
    check("t2_wvalid_c2",  wvalid,  1);
    tick;
    wready = 1;
    check("t2_wvalid_c3", wvalid, 1);
    check("t2_bready_c3", bready, 0);
    tick;
    wready = 0;
    check("t2_wvalid_c4", wvalid, 0);
    check("t2_bready_c4", bready, 1);
    check("t2_d_ready_c4", d_ready, 0);
    tick;
    check("t2_d_ready_c5", d_ready, 0);
    tick;
    bvalid = 1; bresp = 2'b10;
    check("t2_d_ready_c6", d_ready, 0);
    tick;
    bvalid = 0; bresp = 0;
    check("t2_d_ready_c7", d_ready, 1);
    check("t2_bready_c7",  bready,  0);
    check("t2_d_din_hold", d_din, 32'hDEAD_BEEF);
    d_strobe = 0; d_rw = 0;
    tick;
    check("t2_d_ready_c8", d_ready, 0);
    tick;

    // Simultaneous I and D strobes: D first, then I
    i_a = 32'h0000_0300; i_size = 2'd2; i_strobe = 1;
    d_a = 32'h0000_0400; d_size = 2'd2; d_rw = 0; d_strobe = 1; arready = 1;
    tick;
    check("t3_araddr_d", araddr, 32'h0000_0400);
    rvalid = 1; rdata = 32'h1111_1111;
    tick; tick;
    rvalid = 0;
    check("t3_d_ready", d_ready, 1);
    check("t3_i_ready_d", i_ready, 0);
    check("t3_d_din", d_din, 32'h1111_1111);
    d_strobe = 0;
    tick;
    check("t3_idle_arvalid", arvalid, 0);
    tick;
    check("t3_arvalid_i", arvalid, 1);
    check("t3_araddr_i", araddr, 32'h0000_0300);
    rvalid = 1; rdata = 32'h2222_2222;
    tick; tick;
    rvalid = 0;
    check("t3_i_ready", i_ready, 1);
    check("t3_d_ready_i", d_ready, 0);
    check("t3_i_din", i_din, 32'h2222_2222);
    i_strobe = 0;
    tick; tick;

    // Reset while in RD_DATA with rvalid pending
    d_a = 32'h0000_0800; d_size = 2'd2; d_rw = 0; d_strobe = 1; arready = 1;
    tick; tick;
    check("t4_rready_pre", rready, 1);
    rvalid = 1; rdata = 32'hAAAA_5555;
    rst = 1;
    #1;
    check("t4_rready_rst",  rready,  0);
    check("t4_arvalid_rst", arvalid, 0);
    check("t4_d_ready_rst", d_ready, 0);
    check("t4_d_din_rst",   d_din,   0);
    d_strobe = 0; rvalid = 0;
    tick;
    rst = 0;
    check("t4_d_ready_n1", d_ready, 0);
    tick;
    check("t4_d_ready_n2", d_ready, 0);
    check("t4_arvalid_n2", arvalid, 0);
    tick;
    check("t4_d_ready_n3", d_ready, 0);
    check("t4_d_din_n3",   d_din,   0);

    // I read with SLVERR response completes normally
    i_a = 32'h0000_0500; i_size = 2'd0; i_strobe = 1; arready = 1;
    tick;
    check("t5_arsize",  arsize, 3'b000);
    check("t5_araddr",  araddr, 32'h0000_0500);
    rvalid = 1; rresp = 2'b10; rdata = 32'hFFFF_0000;
    tick; tick;
    rvalid = 0; rresp = 0;
    check("t5_i_ready", i_ready, 1);
    check("t5_i_din",   i_din,   32'hFFFF_0000);
    check("t5_d_ready", d_ready, 0);
    i_strobe = 0;
    tick;
    check("t5_i_ready_after", i_ready, 0);
    check("t5_i_din_hold", i_din, 32'hFFFF_0000);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
